// File: rtl/spike_input_encoder.sv
// -----------------------------------------------------------------------------
// spike_input_encoder
//
// Rate-coding input injector. Once per time tick it scans a buffer of
// N = 2^M input values and emits one AER spike event for every neuron whose
// value is at least the current tick. Each full scan ends with a
// time-reference (TREF) event. Ticks count down from 2^INPUT_RESO-1 to 1, so
// a value v produces exactly v spikes for its neuron.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   start_i      start pulse, honoured only while idle
//   abort_i      stop request, honoured in any active state
//   mem_req_o    input-buffer read strobe
//   mem_addr_o   input-buffer read address
//   mem_rdata_i  read data, valid the cycle after mem_req_o
//   aer_valid_o  event valid
//   aer_ready_i  event accepted by the core
//   aer_addr_o   event neuron address
//   aer_tref_o   event is an end-of-tick time reference
//   tick_o       current tick, 0 while idle
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse when a run ends
// -----------------------------------------------------------------------------
module spike_input_encoder #(
    parameter int M          = 8,
    parameter int INPUT_RESO = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  mem_req_o,
    output logic [M-1:0]          mem_addr_o,
    input  logic [INPUT_RESO-1:0] mem_rdata_i,
    output logic                  aer_valid_o,
    input  logic                  aer_ready_i,
    output logic [M-1:0]          aer_addr_o,
    output logic                  aer_tref_o,
    output logic [INPUT_RESO-1:0] tick_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EVAL,
        S_SEND,
        S_NEXT,
        S_TREF,
        S_DONE
    } state_t;

    localparam logic [INPUT_RESO-1:0] TICK_MAX = '1;
    localparam logic [INPUT_RESO-1:0] TICK_ONE = INPUT_RESO'(1);
    localparam logic [M-1:0]          IDX_LAST = '1;

    state_t                  state_q, state_d;
    logic [M-1:0]            idx_q,   idx_d;
    logic [INPUT_RESO-1:0]   tick_q,  tick_d;
    logic [INPUT_RESO-1:0]   pix_q,   pix_d;

    // Next-state logic for the scan. Abort overrides whatever the state
    // would otherwise do; a handshake completing in the same cycle has
    // already been seen by the core, so it simply counts as delivered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        pix_d   = pix_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    tick_d  = TICK_MAX;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                pix_d = mem_rdata_i;
                if (mem_rdata_i >= tick_q) begin
                    state_d = S_SEND;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_SEND: begin
                if (aer_ready_i) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_TREF;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_TREF: begin
                if (aer_ready_i) begin
                    if (tick_q == TICK_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        tick_d  = tick_q - 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                // Clear the scan registers so IDLE always presents tick 0.
                idx_d   = '0;
                tick_d  = '0;
                pix_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_DONE;
        end
    end

    // State and scan registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tick_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            pix_q   <= pix_d;
        end
    end

    // A spike is only ever sent for a pixel that cleared the threshold.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == S_SEND)) begin
            assert (pix_q >= tick_q);
        end
    end

    // Outputs decode the state register only, so aer_ready_i never reaches
    // aer_valid_o combinationally. Addresses are gated so idle outputs are 0.
    assign mem_req_o   = (state_q == S_FETCH);
    assign mem_addr_o  = (state_q == S_FETCH) ? idx_q : '0;
    assign aer_valid_o = (state_q == S_SEND) || (state_q == S_TREF);
    assign aer_addr_o  = (state_q == S_SEND) ? idx_q : '0;
    assign aer_tref_o  = (state_q == S_TREF);
    assign tick_o      = tick_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_spike_input_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_input_encoder
//
// Scoreboard bench for spike_input_encoder with M=2, INPUT_RESO=2. A
// reference model expands the input buffer into the full list of expected
// events (tick by tick, address by address) and queues them when a run is
// started; a monitor pops and compares on every accepted event. Directed
// scenarios cover reset, backpressure, abort, an all-zero buffer with an
// ignored restart, and reset mid-TREF; randomized buffers and ready patterns
// follow.
// -----------------------------------------------------------------------------
module tb_spike_input_encoder;

    localparam int M    = 2;
    localparam int RESO = 2;
    localparam int N    = 1 << M;
    localparam int TMAX = (1 << RESO) - 1;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            start_i = 1'b0;
    logic            abort_i = 1'b0;
    logic            mem_req_o;
    logic [M-1:0]    mem_addr_o;
    logic [RESO-1:0] mem_rdata_i = '0;
    logic            aer_valid_o;
    logic            aer_ready_i = 1'b0;
    logic [M-1:0]    aer_addr_o;
    logic            aer_tref_o;
    logic [RESO-1:0] tick_o;
    logic            busy_o;
    logic            done_o;

    typedef struct {
        bit tref;
        int addr;
        int tick;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    int  mem[N];

    int  checks = 0;
    int  errors = 0;
    int  spike_cnt = 0;
    int  tref_cnt = 0;
    int  done_cnt = 0;
    int  exp_spikes = 0;
    int  ready_mode = 0;
    bit  prev_stall = 1'b0;
    int  prev_addr = 0;
    int  prev_tref = 0;

    spike_input_encoder #(
        .M          (M),
        .INPUT_RESO (RESO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .aer_valid_o (aer_valid_o),
        .aer_ready_i (aer_ready_i),
        .aer_addr_o  (aer_addr_o),
        .aer_tref_o  (aer_tref_o),
        .tick_o      (tick_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Input buffer model: data presented during the cycle after the strobe.
    always @(negedge clk_i) begin
        if (mem_req_o) begin
            mem_rdata_i = RESO'(mem[int'(mem_addr_o)]);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: handshake stability, scoreboard pops and done counting.
    always @(negedge clk_i) begin
        if (prev_stall) begin
            checkOutput("stall valid held", int'(aer_valid_o), 1);
            checkOutput("stall addr held", int'(aer_addr_o), prev_addr);
            checkOutput("stall tref held", int'(aer_tref_o), prev_tref);
        end
        prev_stall = aer_valid_o && !aer_ready_i && !abort_i && !rst_i;
        prev_addr  = int'(aer_addr_o);
        prev_tref  = int'(aer_tref_o);

        if (!rst_i && aer_valid_o && aer_ready_i) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected event", 1, 0);
            end else begin
                mon_ev = exp_q.pop_front();
                checkOutput("event tref", int'(aer_tref_o), int'(mon_ev.tref));
                checkOutput("event addr", int'(aer_addr_o), mon_ev.addr);
                checkOutput("event tick", int'(tick_o), mon_ev.tick);
            end
            if (aer_tref_o) tref_cnt++;
            else            spike_cnt++;
        end

        if (done_o) done_cnt++;
    end

    // Reference model: spikes for every value >= tick, ticks counting down,
    // each tick closed by a TREF event.
    task automatic refModel();
        ev_t e;
        exp_q.delete();
        exp_spikes = 0;
        for (int t = TMAX; t >= 1; t--) begin
            for (int a = 0; a < N; a++) begin
                if (mem[a] >= t) begin
                    e.tref = 1'b0; e.addr = a; e.tick = t;
                    exp_q.push_back(e);
                end
            end
            e.tref = 1'b1; e.addr = 0; e.tick = t;
            exp_q.push_back(e);
        end
        for (int a = 0; a < N; a++) exp_spikes += mem[a];
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        if (ready_mode == 0)      aer_ready_i = 1'b1;
        else if (ready_mode == 1) aer_ready_i = 1'($urandom_range(0, 1));
    endtask

    // Queue the expected events for the current buffer and pulse start.
    task automatic applyStimulus();
        refModel();
        spike_cnt = 0;
        tref_cnt  = 0;
        done_cnt  = 0;
        start_i   = 1'b1;
        step();
        start_i   = 1'b0;
    endtask

    task automatic waitDone(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        checkOutput("done within bound", int'(seen), 1);
    endtask

    // Called in the DONE cycle: checks the cycle after and the run totals.
    task automatic finishRun(input string tag);
        step();
        checkOutput({tag, " busy after done"}, int'(busy_o), 0);
        checkOutput({tag, " tick after done"}, int'(tick_o), 0);
        checkOutput({tag, " done single"}, int'(done_o), 0);
        checkOutput({tag, " spike count"}, spike_cnt, exp_spikes);
        checkOutput({tag, " tref count"}, tref_cnt, TMAX);
        checkOutput({tag, " done count"}, done_cnt, 1);
        checkOutput({tag, " events left"}, exp_q.size(), 0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " mem_req"}, int'(mem_req_o), 0);
        checkOutput({tag, " mem_addr"}, int'(mem_addr_o), 0);
        checkOutput({tag, " aer_valid"}, int'(aer_valid_o), 0);
        checkOutput({tag, " aer_addr"}, int'(aer_addr_o), 0);
        checkOutput({tag, " aer_tref"}, int'(aer_tref_o), 0);
        checkOutput({tag, " tick"}, int'(tick_o), 0);
        checkOutput({tag, " busy"}, int'(busy_o), 0);
        checkOutput({tag, " done"}, int'(done_o), 0);
    endtask

    task automatic loadRamp();
        for (int a = 0; a < N; a++) mem[a] = a;
    endtask

    task automatic runRamp(input string tag);
        loadRamp();
        ready_mode = 0;
        applyStimulus();
        checkOutput({tag, " first mem_req"}, int'(mem_req_o), 1);
        checkOutput({tag, " first mem_addr"}, int'(mem_addr_o), 0);
        checkOutput({tag, " first busy"}, int'(busy_o), 1);
        checkOutput({tag, " first tick"}, int'(tick_o), TMAX);
        waitDone(500);
        finishRun(tag);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int  sends;
        bit  hit;

        ready_mode = 2;
        rst_i = 1'b1;
        repeat (3) step();
        checkIdle("reset");
        rst_i = 1'b0;
        step();

        // Ramp buffer, ready always high.
        runRamp("ramp");

        // Backpressure on the first SEND.
        loadRamp();
        ready_mode  = 2;
        aer_ready_i = 1'b0;
        applyStimulus();
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (aer_valid_o) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        checkOutput("bp first send seen", int'(hit), 1);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp valid", int'(aer_valid_o), 1);
            checkOutput("bp addr", int'(aer_addr_o), 3);
            checkOutput("bp tref", int'(aer_tref_o), 0);
            if (k < 4) step();
        end
        aer_ready_i = 1'b1;
        ready_mode  = 0;
        waitDone(500);
        finishRun("bp");

        // Abort during the second SEND while ready is low.
        loadRamp();
        ready_mode  = 2;
        aer_ready_i = 1'b0;
        applyStimulus();
        sends = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (aer_valid_o) begin
                if (!aer_tref_o) sends++;
                if (!aer_tref_o && sends == 2) begin
                    abort_i = 1'b1;
                    break;
                end
                aer_ready_i = 1'b1;
                step();
                aer_ready_i = 1'b0;
            end
        end
        checkOutput("abort second send reached", sends, 2);
        step();
        abort_i = 1'b0;
        checkOutput("abort valid dropped", int'(aer_valid_o), 0);
        checkOutput("abort done pulse", int'(done_o), 1);
        step();
        checkOutput("abort busy cleared", int'(busy_o), 0);
        checkOutput("abort tick cleared", int'(tick_o), 0);
        checkOutput("abort spikes delivered", spike_cnt, 1);
        checkOutput("abort trefs delivered", tref_cnt, 1);
        checkOutput("abort done count", done_cnt, 1);
        exp_q.delete();

        // All-zero buffer with a start pulse mid-run that must be ignored.
        for (int a = 0; a < N; a++) mem[a] = 0;
        ready_mode = 0;
        applyStimulus();
        repeat (5) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        checkOutput("zero still busy", int'(busy_o), 1);
        waitDone(500);
        finishRun("zero");

        // Reset while a TREF is pending, then a clean rerun.
        loadRamp();
        ready_mode  = 2;
        aer_ready_i = 1'b1;
        applyStimulus();
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (aer_valid_o && aer_tref_o) begin
                aer_ready_i = 1'b0;
                hit = 1'b1;
                break;
            end
        end
        checkOutput("rst tref reached", int'(hit), 1);
        rst_i = 1'b1;
        step();
        checkIdle("mid reset");
        rst_i = 1'b0;
        exp_q.delete();
        step();
        runRamp("rerun");

        // Randomized buffers with random backpressure.
        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < N; a++) mem[a] = int'($urandom_range(0, TMAX));
            ready_mode = 1;
            applyStimulus();
            waitDone(2000);
            finishRun("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
